// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and turns debounced presses into hex nibbles.
// Define KEYPAD_DEBOUNCE_EN to build multi-scan debounce; otherwise every scan is accepted directly.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] value
);

    localparam int            DW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;

    typedef enum logic {
        RELEASED,
        PRESSED
    } state_t;

    if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: SETTLE_CYCLES must be >= 4 and DEBOUNCE_SCANS >= 1");
    end

    // Physical keypad layout, indexed by column*4 + row.
    function automatic logic [3:0] key_at(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0] row_meta;
    logic [3:0] row_sync;

    // NOTE: non-blocking assignments make row_meta/row_sync a true two-stage chain;
    // blocking here would collapse both flops into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    logic [1:0]    col_idx;
    logic [DW-1:0] dwell;
    logic          sample;
    logic          scan_done;

    assign sample    = (dwell == DWELL_LAST);
    assign scan_done = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx <= 2'd0;
            dwell   <= '0;
        end else if (sample) begin
            col_idx <= col_idx + 2'd1;
            dwell   <= '0;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    // Active-high hit bits for columns 0..2; column 3 is evaluated live at its own sample edge.
    logic [2:0][3:0] hits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits <= '0;
        end else if (sample) begin
            case (col_idx)
                2'd0:    hits[0] <= ~row_sync;
                2'd1:    hits[1] <= ~row_sync;
                2'd2:    hits[2] <= ~row_sync;
                default: ;
            endcase
        end
    end

    logic [15:0] matrix;
    logic [4:0]  n_hits;
    logic [3:0]  hit_code;
    scan_res_t   cur;

    assign matrix = {~row_sync, hits};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        n_hits   = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (matrix[i]) begin
                n_hits   = n_hits + 5'd1;
                hit_code = key_at(4'(i));
            end
        end
        cur.kind = RES_NONE;
        cur.code = 4'h0;
        if (n_hits == 5'd1) begin
            cur.kind = RES_KEY;
            cur.code = hit_code;
        end else if (n_hits > 5'd1) begin
            cur.kind = RES_MULTI;
        end
    end

    logic stable;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int            MW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [MW-1:0] MATCH_N = MW'(DEBOUNCE_SCANS);

    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_next;
    scan_res_t     prev_res;

    always_comb begin
        match_next = MW'(1);
        if (cur.kind == RES_MULTI) begin
            match_next = '0;
        end else if (cur == prev_res) begin
            match_next = (match_cnt == MATCH_N) ? match_cnt : match_cnt + 1'b1;
        end
    end

    assign stable = (cur.kind != RES_MULTI) && (match_next == MATCH_N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
            prev_res  <= '{kind: RES_NONE, code: 4'h0};
        end else if (scan_done) begin
            match_cnt <= match_next;
            prev_res  <= cur;
        end
    end
`else
    assign stable = (cur.kind != RES_MULTI);
`endif

    state_t state_q;
    state_t state_d;
    logic   press_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // A different stable key while PRESSED is ignored until a stable release.
    always_comb begin
        state_d   = state_q;
        press_evt = 1'b0;
        if (scan_done && stable) begin
            case (state_q)
                RELEASED: begin
                    if (cur.kind == RES_KEY) begin
                        press_evt = 1'b1;
                        state_d   = PRESSED;
                    end
                end
                PRESSED: begin
                    if (cur.kind == RES_NONE) begin
                        state_d = RELEASED;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    assign key_down = (state_q == PRESSED);

    // clear takes priority over the shift when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            value     <= 16'h0000;
        end else begin
            key_valid <= press_evt;
            if (press_evt) begin
                key_code <= cur.code;
            end
            if (clear) begin
                value <= 16'h0000;
            end else if (press_evt) begin
                value <= {value[11:0], cur.code};
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: keypad matrix model, per-scan reference model, pulse monitor.
module tb_keypad_scanner;

    localparam int SETTLE      = 4;
    localparam int DEB         = 2;
    localparam int SCAN_CYCLES = 4 * SETTLE;
    localparam int R_NONE      = -1;
    localparam int R_MULTI     = 16;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] value;

    logic [15:0] pressed = '0;   // bit k set while hex key k is held

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] value;
        int          cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          hist[$];
    bit          m_pressed = 1'b0;
    logic [3:0]  m_code    = 4'h0;
    logic [15:0] m_value   = 16'h0;
    int          scan_idx  = 0;

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .clear    (clear),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down),
        .value    (value)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [3:0] key_at(input int c, input int r);
        case (c * 4 + r)
            0:  return 4'h1;
            1:  return 4'h4;
            2:  return 4'h7;
            3:  return 4'h0;
            4:  return 4'h2;
            5:  return 4'h5;
            6:  return 4'h8;
            7:  return 4'hF;
            8:  return 4'h3;
            9:  return 4'h6;
            10: return 4'h9;
            11: return 4'hE;
            12: return 4'hA;
            13: return 4'hB;
            14: return 4'hC;
            default: return 4'hD;
        endcase
    endfunction

    function automatic logic [15:0] key_bit(input int code);
        return 16'(1) << code;
    endfunction

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && pressed[key_at(c, r)]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per full scan, using the keys held during that scan.
    task automatic model_scan(input logic clr);
        int res;
        int run;
        bit stable;
        res = R_NONE;
        if ($countones(pressed) > 1) res = R_MULTI;
        else for (int k = 0; k < 16; k++) if (pressed[k]) res = k;
        scan_idx++;
        hist.push_back(res);
        if (hist.size() > 8) void'(hist.pop_front());
        run = 0;
        if (res != R_MULTI)
            for (int i = hist.size() - 1; i >= 0 && hist[i] == res; i--) run++;
        stable = DEB_EN ? (run >= DEB) : (res != R_MULTI);
        if (!m_pressed && stable && res >= 0 && res < 16) begin
            m_pressed = 1'b1;
            m_code    = res[3:0];
            m_value   = clr ? 16'h0 : {m_value[11:0], res[3:0]};
            exp_q.push_back('{res[3:0], m_value, scan_idx * SCAN_CYCLES});
        end else begin
            if (clr) m_value = 16'h0;
            if (m_pressed && stable && res == R_NONE) m_pressed = 1'b0;
        end
    endtask

    // One full scan: keys change right after a scan boundary and hold for the whole scan.
    task automatic run_scan(input logic [15:0] keys, input logic clr);
        pressed = keys;
        repeat (SCAN_CYCLES - 1) @(posedge clk);
        @(negedge clk);
        clear = clr;
        model_scan(clr);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("key_down", key_down, m_pressed);
        check("value", value, m_value);
        check("key_code", key_code, m_code);
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_col;
        exp_col = ~(4'b0001 << ((cyc / SETTLE) % 4));
        check("col", col, exp_col);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && key_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: key_code 0x%0h at cycle %0d, expected no pulse", key_code, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_code", key_code, e.code);
                check("pulse_value", value, e.value);
                check("pulse_cycle", cyc, e.cycle);
                check("pulse_key_down", key_down, 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          typed[5];
        int          p0;
        int          r;
        logic [15:0] v0;
        logic [15:0] keys;
        typed[0] = 1; typed[1] = 2; typed[2] = 3; typed[3] = 10; typed[4] = 11;
        keys = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_down", key_down, 1'b0);
        check("rst_value", value, 16'h0);
        reset = 1'b0;

        repeat (10) run_scan('0, 1'b0);
        check("idle_pulses", pulses, 0);
        check("idle_value", value, 16'h0);

        repeat (6) run_scan(key_bit(5), 1'b0);
        check("hold5_pulses", pulses, 1);
        check("hold5_value", value, 16'h0005);
        check("hold5_code", key_code, 4'h5);
        check("hold5_down", key_down, 1'b1);
        repeat (3) run_scan('0, 1'b0);
        check("rel5_down", key_down, 1'b0);

        for (int i = 0; i < 5; i++) begin
            repeat (3) run_scan(key_bit(typed[i]), 1'b0);
            repeat (3) run_scan('0, 1'b0);
            check("typed_release_down", key_down, 1'b0);
        end
        check("typed_value", value, 16'h23AB);

        p0 = pulses;
        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? key_bit(7) : 16'h0, 1'b0);
        check("bounce_pulses", pulses - p0, DEB_EN ? 0 : 3);
        repeat (3) run_scan(key_bit(7), 1'b0);
        check("bounce_code", key_code, 4'h7);
        check("bounce_value", value, DEB_EN ? 16'h3AB7 : 16'h7777);
        repeat (3) run_scan('0, 1'b0);

        p0 = pulses;
        v0 = value;
        repeat (4) run_scan(key_bit(1) | key_bit(15), 1'b0);
        check("multi_pulses", pulses - p0, 0);
        check("multi_value", value, v0);
        repeat (3) run_scan(key_bit(1), 1'b0);
        check("multi_release_pulses", pulses - p0, 1);
        check("multi_release_code", key_code, 4'h1);
        repeat (3) run_scan('0, 1'b0);

        for (int i = 0; i < 3; i++) run_scan(key_bit(9), i == (DEB_EN ? DEB - 1 : 0));
        check("clear_value", value, 16'h0);
        check("clear_code", key_code, 4'h9);

        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_col", col, 4'b1110);
        check("midrst_key_code", key_code, 4'h0);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_down", key_down, 1'b0);
        check("midrst_value", value, 16'h0);
        exp_q.delete();
        hist.delete();
        m_pressed = 1'b0;
        m_code    = 4'h0;
        m_value   = 16'h0;
        scan_idx  = 0;
        @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        repeat (3) run_scan(key_bit(9), 1'b0);
        check("repress_pulses", pulses - p0, 1);
        check("repress_value", value, 16'h0009);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r >= 5 && r < 7)      keys = '0;
            else if (r >= 7 && r < 9) keys = key_bit($urandom_range(0, 15));
            else if (r == 9)          keys = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
            run_scan(keys, $urandom_range(0, 19) == 0);
        end
        repeat (3) run_scan('0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
